alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//   Operand-fetch stage directly upstream of the combinational ALU. Holds the
//   architectural register file (2 read, 1 write), selects register or
//   immediate for operand B, and registers {InputA, InputB, OP} in a one-deep
//   valid/ready pipeline slot that drives the ALU. Writeback feeds the write port.
// PARAMETERS
//   W    8  data width; matches ALU W
//   Ops  4  opcode width; matches ALU Ops
//   A    3  register address bits; NREG = 2**A entries
// PORTS
//   Clk       in   1    clock, rising edge
//   Reset_n   in   1    asynchronous, active-low reset
//   InValid   in   1    decode presents a valid request
//   InReady   out  1    stage can accept this cycle
//   RdAddrA   in   A    register index for operand A
//   RdAddrB   in   A    register index for operand B
//   ImmEn     in   1    1: operand B = Imm, 0: operand B = rf[RdAddrB]
//   Imm       in   W    immediate operand
//   OpIn      in   Ops  ALU opcode from decode
//   WrEn      in   1    writeback enable
//   WrAddr    in   A    writeback register index
//   WrData    in   W    writeback data
//   OutValid  out  1    InputA/InputB/OP hold a valid operation
//   OutReady  in   1    consumer (ALU/writeback) accepts this cycle
//   InputA    out  W    operand A to ALU
//   InputB    out  W    operand B to ALU
//   OP        out  Ops  opcode to ALU
// BEHAVIOUR
// - Reset (Reset_n=0, async, any cycle incl. mid-transfer): all rf entries=0,
//   OutValid=0, InputA=0, InputB=0, OP=0; InReady=1 from first cycle after release.
// - Write port: rising edge with WrEn=1 -> rf[WrAddr]<=WrData. All NREG entries writable.
// - Read: combinational; bypass when WrEn && WrAddr==RdAddrX -> read WrData
//   (same-cycle write visible to capture). Bypass applies to A and B independently.
// - InReady = !OutValid || OutReady (combinational; full throughput, no bubble).
// - Accept = InValid && InReady: next edge captures InputA=readA,
//   InputB = ImmEn ? Imm : readB, OP=OpIn; OutValid<=1.
// - No accept and OutReady=1 -> OutValid<=0; outputs keep last values.
// - OutValid && !OutReady (stall): InputA/InputB/OP/OutValid held stable;
//   InValid ignored (InReady=0). Writes to rf continue during stall and do NOT
//   alter captured operands (snapshot semantics; hazards resolved by decode).
// - Simultaneous drain+accept (OutValid&&OutReady&&InValid): new op replaces
//   old in the same edge, OutValid stays 1.
// - Latency: request accepted on edge N appears on outputs after edge N, i.e.
//   1 cycle. Throughput 1 op/cycle while OutReady=1.
// - Widths: no arithmetic in this block; all paths exactly W / Ops / A bits.
// CONFIGURATION
//   OPERAND_STAGE_PERF_EN defined: adds outputs AcceptCnt[15:0] (increments on
//   each accept) and StallCnt[15:0] (increments each cycle OutValid&&!OutReady);
//   both saturate at 16'hFFFF, reset to 0 asynchronously.
//   Not defined: ports and counters absent; functional behaviour identical.
// TESTING
// 1 Reset: hold Reset_n=0 with WrEn=1 -> OutValid=0, InputA/B=0, OP=0; after
//   release read r0..r7 via ops -> all 0.
// 2 Write r3=8'h5A, then InValid=1,RdAddrA=3,ImmEn=1,Imm=8'h11,OpIn=4'h0 ->
//   next cycle OutValid=1, InputA=8'h5A, InputB=8'h11, OP=4'h0.
// 3 Bypass: same cycle WrEn=1,WrAddr=2,WrData=8'hC3 and accept RdAddrA=2,
//   RdAddrB=2,ImmEn=0 -> InputA=InputB=8'hC3.
// 4 Stall: OutReady=0 for 3 cycles with InValid=1 and r3 rewritten to 8'h00
//   -> InReady=0, outputs hold 8'h5A; OutReady=1 -> next op accepted same cycle.
// 5 Back-to-back: 4 accepts with OutReady=1 -> 4 consecutive OutValid cycles,
//   no bubble; then InValid=0 -> OutValid=0 next cycle.
// 6 Async reset asserted mid-stall -> OutValid=0 immediately (before next edge);
//   with OPERAND_STAGE_PERF_EN, AcceptCnt/StallCnt read 0.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: decode request, writeback port and the registered ALU operand slot.
// One bundle so the stage and its neighbours share a single parameterised port.
interface alu_operand_stage_if #(
   parameter int W   = 8,
   parameter int Ops = 4,
   parameter int A   = 3
);
   logic           InValid;
   logic           InReady;
   logic [A-1:0]   RdAddrA;
   logic [A-1:0]   RdAddrB;
   logic           ImmEn;
   logic [W-1:0]   Imm;
   logic [Ops-1:0] OpIn;
   logic           WrEn;
   logic [A-1:0]   WrAddr;
   logic [W-1:0]   WrData;
   logic           OutValid;
   logic           OutReady;
   logic [W-1:0]   InputA;
   logic [W-1:0]   InputB;
   logic [Ops-1:0] OP;

   modport master (
      output InValid, RdAddrA, RdAddrB, ImmEn, Imm, OpIn,
             WrEn, WrAddr, WrData, OutReady,
      input  InReady, OutValid, InputA, InputB, OP
   );

   modport slave (
      input  InValid, RdAddrA, RdAddrB, ImmEn, Imm, OpIn,
             WrEn, WrAddr, WrData, OutReady,
      output InReady, OutValid, InputA, InputB, OP
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand fetch ahead of the ALU: 2R/1W register file with write bypass, imm mux, one-deep slot.
// OPERAND_STAGE_PERF_EN adds saturating accept/stall counters.
module alu_operand_stage #(
   parameter int W   = 8,
   parameter int Ops = 4,
   parameter int A   = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   alu_operand_stage_if.slave   bus
`ifdef OPERAND_STAGE_PERF_EN
   ,
   output logic [15:0]          o_AcceptCnt,
   output logic [15:0]          o_StallCnt
`endif
);
   localparam int NREG = 2**A;

   logic [W-1:0]   r_rf [NREG];
   logic           r_vld;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [Ops-1:0] r_op;

   logic [W-1:0]   w_rd_a;
   logic [W-1:0]   w_rd_b;
   logic           w_in_ready;
   logic           w_accept;

   // Same-cycle writeback is forwarded so the captured operand sees it.
   assign w_rd_a = (bus.WrEn && (bus.WrAddr == bus.RdAddrA)) ? bus.WrData : r_rf[bus.RdAddrA];
   assign w_rd_b = (bus.WrEn && (bus.WrAddr == bus.RdAddrB)) ? bus.WrData : r_rf[bus.RdAddrB];

   assign w_in_ready = !r_vld || bus.OutReady;
   assign w_accept   = bus.InValid && w_in_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (bus.WrEn) begin
         r_rf[bus.WrAddr] <= bus.WrData;
      end
   end

   // Operands are a snapshot: later writes never touch a held slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_op  <= '0;
      end else if (w_accept) begin
         r_vld <= 1'b1;
         r_a   <= w_rd_a;
         r_b   <= bus.ImmEn ? bus.Imm : w_rd_b;
         r_op  <= bus.OpIn;
      end else if (bus.OutReady) begin
         r_vld <= 1'b0;
      end
   end

   assign bus.InReady  = w_in_ready;
   assign bus.OutValid = r_vld;
   assign bus.InputA   = r_a;
   assign bus.InputB   = r_b;
   assign bus.OP       = r_op;

`ifdef OPERAND_STAGE_PERF_EN
   logic [15:0] r_acc_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_accept && (r_acc_cnt != 16'hFFFF))
            r_acc_cnt <= r_acc_cnt + 16'd1;
         if (r_vld && !bus.OutReady && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign o_AcceptCnt = r_acc_cnt;
   assign o_StallCnt  = r_stall_cnt;
`else
   // Counters not built; the datapath is unchanged.
`endif
endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed bench for alu_operand_stage against a transaction-level model.
module tb_alu_operand_stage;
   localparam int W   = 8;
   localparam int Ops = 4;
   localparam int A   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_operand_stage_if #(.W(W), .Ops(Ops), .A(A)) bus ();

`ifdef OPERAND_STAGE_PERF_EN
   logic [15:0] acc_cnt, stall_cnt;
   alu_operand_stage #(.W(W), .Ops(Ops), .A(A)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
      .o_AcceptCnt(acc_cnt), .o_StallCnt(stall_cnt));
`else
   alu_operand_stage #(.W(W), .Ops(Ops), .A(A)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus));
`endif

   // Model: registers as an array; a cycle applies the write, then takes a snapshot.
   logic [W-1:0]   m_rf [8];
   logic           m_vld;
   logic [W-1:0]   m_a, m_b;
   logic [Ops-1:0] m_op;
   int             m_acc, m_stall;
   logic           m_take;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_rf[i] = '0;
         m_vld = 0; m_a = '0; m_b = '0; m_op = '0; m_acc = 0; m_stall = 0;
      end else begin
         m_take = bus.InValid && (!m_vld || bus.OutReady);
         if (m_vld && !bus.OutReady && m_stall < 65535) m_stall++;
         if (m_take && m_acc < 65535) m_acc++;
         if (bus.WrEn) m_rf[bus.WrAddr] = bus.WrData;
         if (m_take) begin
            m_vld = 1;
            m_a   = m_rf[bus.RdAddrA];
            m_b   = bus.ImmEn ? bus.Imm : m_rf[bus.RdAddrB];
            m_op  = bus.OpIn;
         end else if (bus.OutReady) begin
            m_vld = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      chk("OutValid", 32'(bus.OutValid), 32'(m_vld));
      chk("InReady",  32'(bus.InReady),  32'(!m_vld || bus.OutReady));
      chk("InputA",   32'(bus.InputA),   32'(m_a));
      chk("InputB",   32'(bus.InputB),   32'(m_b));
      chk("OP",       32'(bus.OP),       32'(m_op));
`ifdef OPERAND_STAGE_PERF_EN
      chk("AcceptCnt", 32'(acc_cnt),   32'(m_acc));
      chk("StallCnt",  32'(stall_cnt), 32'(m_stall));
`endif
   endtask

   // One clock; outputs are checked on the falling edge, then the caller drives.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cmp_model();
   endtask

   task automatic req(input logic v, input logic [A-1:0] ra, input logic [A-1:0] rb,
                      input logic ie, input logic [W-1:0] im, input logic [Ops-1:0] op);
      bus.InValid = v; bus.RdAddrA = ra; bus.RdAddrB = rb;
      bus.ImmEn = ie; bus.Imm = im; bus.OpIn = op;
   endtask

   task automatic wr(input logic en, input logic [A-1:0] ad, input logic [W-1:0] d);
      bus.WrEn = en; bus.WrAddr = ad; bus.WrData = d;
   endtask

   initial begin
      req(0, 0, 0, 0, 0, 0);
      wr(1, 3'd5, 8'hEE);
      bus.OutReady = 1;
      #1 rst_n = 0;
      // Reset held with a write pending
      repeat (3) tick();
      chk("rst_OutValid", 32'(bus.OutValid), 0);
      chk("rst_InputA",   32'(bus.InputA), 0);
      chk("rst_InputB",   32'(bus.InputB), 0);
      chk("rst_OP",       32'(bus.OP), 0);
      rst_n = 1;
      wr(0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         req(1, 3'(i), 3'(i), 0, 8'hFF, 4'(i));
         tick();
         chk("rst_rf_A", 32'(bus.InputA), 0);
         chk("rst_rf_B", 32'(bus.InputB), 0);
      end

      // Register write then immediate op
      req(0, 0, 0, 0, 0, 0); wr(1, 3'd3, 8'h5A); tick();
      wr(0, 0, 0); req(1, 3'd3, 3'd0, 1, 8'h11, 4'h0); tick();
      chk("t2_OutValid", 32'(bus.OutValid), 1);
      chk("t2_InputA",   32'(bus.InputA), 32'h5A);
      chk("t2_InputB",   32'(bus.InputB), 32'h11);
      chk("t2_OP",       32'(bus.OP), 0);

      // Bypass on both read ports
      wr(1, 3'd2, 8'hC3); req(1, 3'd2, 3'd2, 0, 8'h00, 4'h5); tick();
      chk("t3_InputA", 32'(bus.InputA), 32'hC3);
      chk("t3_InputB", 32'(bus.InputB), 32'hC3);

      // Stall with r3 overwritten underneath the held op
      wr(0, 0, 0); req(1, 3'd3, 3'd0, 1, 8'h22, 4'h7); tick();
      bus.OutReady = 0; wr(1, 3'd3, 8'h00); req(1, 3'd1, 3'd2, 0, 8'h99, 4'h9);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_InReady", 32'(bus.InReady), 0);
         chk("t4_InputA",  32'(bus.InputA), 32'h5A);
         chk("t4_OP",      32'(bus.OP), 32'h7);
      end
      bus.OutReady = 1; wr(0, 0, 0); req(1, 3'd3, 3'd2, 0, 8'h00, 4'hA);
      #1 chk("t4_InReady_rel", 32'(bus.InReady), 1);
      tick();
      chk("t4_next_A",  32'(bus.InputA), 32'h00);
      chk("t4_next_B",  32'(bus.InputB), 32'hC3);
      chk("t4_next_OP", 32'(bus.OP), 32'hA);

      // Back-to-back accepts, then drain
      for (int i = 0; i < 4; i++) begin
         req(1, 3'd2, 3'd2, 1, 8'(i), 4'(i)); tick();
         chk("t5_OutValid", 32'(bus.OutValid), 1);
         chk("t5_InputB",   32'(bus.InputB), 32'(i));
      end
      req(0, 0, 0, 0, 0, 0); tick();
      chk("t5_drain", 32'(bus.OutValid), 0);

      // Async reset in the middle of a stall
      req(1, 3'd2, 3'd2, 0, 0, 4'h3); tick();
      bus.OutReady = 0; req(0, 0, 0, 0, 0, 0); tick(); tick();
      rst_n = 0;
      #1;
      chk("t6_OutValid", 32'(bus.OutValid), 0);
      chk("t6_InputA",   32'(bus.InputA), 0);
`ifdef OPERAND_STAGE_PERF_EN
      chk("t6_AcceptCnt", 32'(acc_cnt), 0);
      chk("t6_StallCnt",  32'(stall_cnt), 0);
`endif
      cmp_model();
      tick();
      rst_n = 1;
      tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         req(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 1'($urandom),
             8'($urandom), 4'($urandom));
         wr(1'($urandom), 3'($urandom), 8'($urandom));
         bus.OutReady = 1'($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
